// File: rtl/e_pipe_reg.sv
// e_pipe_reg: decode-to-execute (E) pipeline register of the Y86 pipeline,
// plus the architectural condition-code register read by execute.
//
// Ports:
//   clk, rst          clock; synchronous active-low reset
//   E_stall_i         hold the E register this cycle
//   E_bubble_i        load a nop bubble this cycle (wins over stall)
//   D_*/d_* inputs    decode-stage stat/icode/ifun/valA/valB/valC/dstE/dstM
//   set_cc_i, cc_i    commit new flags {zf,sf,of}
//   E_*_o             registered decode values presented to execute
//   cc_o              architectural flags {zf,sf,of}
//   bubble_cnt_o      saturating count of bubbles injected since reset
//   ctrl_err_o        sticky: stall and bubble requested together
module e_pipe_reg #(
    parameter int WORD_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              E_stall_i,
    input  logic              E_bubble_i,
    input  logic [3:0]        D_stat_i,
    input  logic [3:0]        D_icode_i,
    input  logic [3:0]        D_ifun_i,
    input  logic [WORD_W-1:0] d_valA_i,
    input  logic [WORD_W-1:0] d_valB_i,
    input  logic [WORD_W-1:0] D_valC_i,
    input  logic [3:0]        d_dstE_i,
    input  logic [3:0]        d_dstM_i,
    input  logic              set_cc_i,
    input  logic [2:0]        cc_i,
    output logic [3:0]        E_stat_o,
    output logic [3:0]        E_icode_o,
    output logic [3:0]        E_ifun_o,
    output logic [WORD_W-1:0] E_valA_o,
    output logic [WORD_W-1:0] E_valB_o,
    output logic [WORD_W-1:0] E_valC_o,
    output logic [3:0]        E_dstE_o,
    output logic [3:0]        E_dstM_o,
    output logic [2:0]        cc_o,
    output logic [CNT_W-1:0]  bubble_cnt_o,
    output logic              ctrl_err_o
);

    typedef struct packed {
        logic [3:0]        stat;
        logic [3:0]        icode;
        logic [3:0]        ifun;
        logic [WORD_W-1:0] val_a;
        logic [WORD_W-1:0] val_b;
        logic [WORD_W-1:0] val_c;
        logic [3:0]        dst_e;
        logic [3:0]        dst_m;
    } e_t;

    // nop bubble: SBUB / INOP, zero operands, no destination (RNONE)
    localparam e_t BUBBLE = '{
        stat:  4'h0,
        icode: 4'h1,
        ifun:  4'h0,
        val_a: '0,
        val_b: '0,
        val_c: '0,
        dst_e: 4'hF,
        dst_m: 4'hF
    };

    e_t               e_q;
    e_t               d_in;
    logic [2:0]       cc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;

    assign d_in = '{
        stat:  D_stat_i,
        icode: D_icode_i,
        ifun:  D_ifun_i,
        val_a: d_valA_i,
        val_b: d_valB_i,
        val_c: D_valC_i,
        dst_e: d_dstE_i,
        dst_m: d_dstM_i
    };

    // bubble beats stall; reset restarts from the bubble value
    always_ff @(posedge clk) begin
        if (!rst)
            e_q <= BUBBLE;
        else if (E_bubble_i)
            e_q <= BUBBLE;
        else if (!E_stall_i)
            e_q <= d_in;
    end

    // flags are not gated by stall/bubble; execute already qualifies set_cc_i
    always_ff @(posedge clk) begin
        if (!rst)
            cc_q <= 3'b100;
        else if (set_cc_i)
            cc_q <= cc_i;
    end

    // saturating bubble counter; counts bubbles even when stall is also raised
    always_ff @(posedge clk) begin
        if (!rst)
            cnt_q <= '0;
        else if (E_bubble_i && (cnt_q != {CNT_W{1'b1}}))
            cnt_q <= cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst)
            err_q <= 1'b0;
        else if (E_bubble_i && E_stall_i)
            err_q <= 1'b1;
    end

    assign E_stat_o     = e_q.stat;
    assign E_icode_o    = e_q.icode;
    assign E_ifun_o     = e_q.ifun;
    assign E_valA_o     = e_q.val_a;
    assign E_valB_o     = e_q.val_b;
    assign E_valC_o     = e_q.val_c;
    assign E_dstE_o     = e_q.dst_e;
    assign E_dstM_o     = e_q.dst_m;
    assign cc_o         = cc_q;
    assign bubble_cnt_o = cnt_q;
    assign ctrl_err_o   = err_q;

endmodule

// File: tb/tb_e_pipe_reg.sv
// Bench for e_pipe_reg: directed phases with literal expectations plus
// randomized traffic checked every cycle against a behavioural model.
module tb_e_pipe_reg;

    localparam int WORD_W = 32;
    localparam int CNT_W  = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              E_stall_i, E_bubble_i;
    logic [3:0]        D_stat_i, D_icode_i, D_ifun_i;
    logic [WORD_W-1:0] d_valA_i, d_valB_i, D_valC_i;
    logic [3:0]        d_dstE_i, d_dstM_i;
    logic              set_cc_i;
    logic [2:0]        cc_i;
    logic [3:0]        E_stat_o, E_icode_o, E_ifun_o;
    logic [WORD_W-1:0] E_valA_o, E_valB_o, E_valC_o;
    logic [3:0]        E_dstE_o, E_dstM_o;
    logic [2:0]        cc_o;
    logic [CNT_W-1:0]  bubble_cnt_o;
    logic              ctrl_err_o;

    int checks = 0;
    int errors = 0;

    e_pipe_reg #(.WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .E_stall_i(E_stall_i), .E_bubble_i(E_bubble_i),
        .D_stat_i(D_stat_i), .D_icode_i(D_icode_i), .D_ifun_i(D_ifun_i),
        .d_valA_i(d_valA_i), .d_valB_i(d_valB_i), .D_valC_i(D_valC_i),
        .d_dstE_i(d_dstE_i), .d_dstM_i(d_dstM_i),
        .set_cc_i(set_cc_i), .cc_i(cc_i),
        .E_stat_o(E_stat_o), .E_icode_o(E_icode_o), .E_ifun_o(E_ifun_o),
        .E_valA_o(E_valA_o), .E_valB_o(E_valB_o), .E_valC_o(E_valC_o),
        .E_dstE_o(E_dstE_o), .E_dstM_o(E_dstM_o),
        .cc_o(cc_o), .bubble_cnt_o(bubble_cnt_o), .ctrl_err_o(ctrl_err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // E contents as a plain array of the eight fields, in output order.
    logic [31:0] m_e [8];
    logic [2:0]  m_cc;
    int          m_cnt;
    logic        m_err;
    logic        m_ok = 1'b0;

    always @(posedge clk) begin
        logic [31:0] bub [8];
        logic [31:0] din [8];
        bub = '{32'h0, 32'h1, 32'h0, 32'h0, 32'h0, 32'h0, 32'hF, 32'hF};
        din = '{32'(D_stat_i), 32'(D_icode_i), 32'(D_ifun_i), d_valA_i, d_valB_i,
                D_valC_i, 32'(d_dstE_i), 32'(d_dstM_i)};
        if (rst === 1'b0) begin
            m_e   = bub;
            m_cc  = 3'b100;
            m_cnt = 0;
            m_err = 1'b0;
            m_ok  = 1'b1;
        end else begin
            if (E_bubble_i)      m_e = bub;
            else if (!E_stall_i) m_e = din;
            if (set_cc_i) m_cc = cc_i;
            if (E_bubble_i) m_cnt = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
            if (E_bubble_i && E_stall_i) m_err = 1'b1;
        end
    end

    // single compare process: every cycle once the model has seen a reset
    always @(negedge clk) begin
        if (m_ok) begin
            chk("m_stat",  32'(E_stat_o),  m_e[0]);
            chk("m_icode", 32'(E_icode_o), m_e[1]);
            chk("m_ifun",  32'(E_ifun_o),  m_e[2]);
            chk("m_valA",  E_valA_o,       m_e[3]);
            chk("m_valB",  E_valB_o,       m_e[4]);
            chk("m_valC",  E_valC_o,       m_e[5]);
            chk("m_dstE",  32'(E_dstE_o),  m_e[6]);
            chk("m_dstM",  32'(E_dstM_o),  m_e[7]);
            chk("m_cc",    32'(cc_o),      32'(m_cc));
            chk("m_cnt",   32'(bubble_cnt_o), 32'(m_cnt));
            chk("m_err",   32'(ctrl_err_o),   32'(m_err));
        end
    end

    // ---------------- stimulus ----------------
    task automatic rand_d();
        D_stat_i  = 4'($urandom);
        D_icode_i = 4'($urandom);
        D_ifun_i  = 4'($urandom);
        d_valA_i  = $urandom;
        d_valB_i  = $urandom;
        D_valC_i  = $urandom;
        d_dstE_i  = 4'($urandom);
        d_dstM_i  = 4'($urandom);
    endtask

    task automatic edge_();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; E_stall_i = 1'b0; E_bubble_i = 1'b0;
        set_cc_i = 1'b0; cc_i = 3'b000;
        rand_d();

        // reset with random D inputs for two edges
        edge_(); rand_d(); edge_();
        chk("rst_icode", 32'(E_icode_o), 32'h1);
        chk("rst_stat",  32'(E_stat_o),  32'h0);
        chk("rst_dstE",  32'(E_dstE_o),  32'hF);
        chk("rst_dstM",  32'(E_dstM_o),  32'hF);
        chk("rst_valA",  E_valA_o, 32'h0);
        chk("rst_valC",  E_valC_o, 32'h0);
        chk("rst_cc",    32'(cc_o), 32'b100);
        chk("rst_cnt",   32'(bubble_cnt_o), 32'h0);
        chk("rst_err",   32'(ctrl_err_o), 32'h0);

        // normal load, then the next D value one edge later
        rst = 1'b1;
        D_stat_i = 4'h1; D_icode_i = 4'h6; D_ifun_i = 4'h1;
        d_valA_i = 32'h5; d_valB_i = 32'h9; D_valC_i = 32'h0;
        d_dstE_i = 4'h3; d_dstM_i = 4'hF;
        edge_();
        chk("ld_icode", 32'(E_icode_o), 32'h6);
        chk("ld_ifun",  32'(E_ifun_o),  32'h1);
        chk("ld_valA",  E_valA_o, 32'h5);
        chk("ld_valB",  E_valB_o, 32'h9);
        chk("ld_dstE",  32'(E_dstE_o), 32'h3);
        chk("ld_stat",  32'(E_stat_o), 32'h1);
        D_icode_i = 4'h2; d_valA_i = 32'h77;
        edge_();
        chk("ld2_icode", 32'(E_icode_o), 32'h2);
        chk("ld2_valA",  E_valA_o, 32'h77);

        // irmovl, then three stalled cycles with changing D
        D_icode_i = 4'h3; D_ifun_i = 4'h0; D_valC_i = 32'h100; d_dstE_i = 4'h2;
        edge_();
        for (int i = 0; i < 3; i++) begin
            E_stall_i = 1'b1;
            rand_d();
            edge_();
            chk("stall_icode", 32'(E_icode_o), 32'h3);
            chk("stall_valC",  E_valC_o, 32'h100);
        end
        E_stall_i = 1'b0;
        D_icode_i = 4'h5; D_valC_i = 32'hABCD;
        edge_();
        chk("rel_icode", 32'(E_icode_o), 32'h5);
        chk("rel_valC",  E_valC_o, 32'hABCD);

        // stall and bubble together
        E_stall_i = 1'b1; E_bubble_i = 1'b1;
        edge_();
        chk("sb_icode", 32'(E_icode_o), 32'h1);
        chk("sb_dstE",  32'(E_dstE_o), 32'hF);
        chk("sb_err",   32'(ctrl_err_o), 32'h1);
        chk("sb_cnt",   32'(bubble_cnt_o), 32'h1);
        E_stall_i = 1'b0; E_bubble_i = 1'b0;
        edge_();
        chk("sb_err_sticky", 32'(ctrl_err_o), 32'h1);
        rst = 1'b0;
        edge_();
        chk("sb_err_clr", 32'(ctrl_err_o), 32'h0);
        rst = 1'b1;

        // condition codes
        set_cc_i = 1'b1; cc_i = 3'b011;
        edge_();
        chk("cc_set", 32'(cc_o), 32'b011);
        set_cc_i = 1'b0; cc_i = 3'b100;
        edge_();
        chk("cc_hold", 32'(cc_o), 32'b011);
        E_stall_i = 1'b1; set_cc_i = 1'b1; cc_i = 3'b110;
        edge_();
        chk("cc_stall", 32'(cc_o), 32'b110);
        E_stall_i = 1'b0; set_cc_i = 1'b0;

        // saturation of the bubble counter
        rst = 1'b0; edge_(); rst = 1'b1;
        E_bubble_i = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            edge_();
            chk("sat_cnt", 32'(bubble_cnt_o), (i > 15) ? 32'd15 : 32'(i));
        end
        E_bubble_i = 1'b0;

        // randomized traffic, including occasional resets
        for (int i = 0; i < 3000; i++) begin
            rand_d();
            rst        = ($urandom_range(0, 63) != 0);
            E_stall_i  = ($urandom_range(0, 3) == 0);
            E_bubble_i = ($urandom_range(0, 5) == 0);
            set_cc_i   = ($urandom_range(0, 1) == 0);
            cc_i       = 3'($urandom);
            edge_();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
